// File: rtl/riscv_ppreg_skid_if.sv
// rtl/riscv_ppreg_skid_if.sv - valid/ready payload bundle between two pipeline stages
interface riscv_ppreg_skid_if #(
    parameter int DATA_W = 64
);
    logic              i_riscv_pps_valid;
    logic              o_riscv_pps_ready;
    logic [DATA_W-1:0] i_riscv_pps_data;
    logic              o_riscv_pps_valid;
    logic              i_riscv_pps_ready;
    logic [DATA_W-1:0] o_riscv_pps_data;

    // Stage-register view: consumes the upstream side, produces the downstream side.
    modport slave (
        input  i_riscv_pps_valid,
        input  i_riscv_pps_data,
        input  i_riscv_pps_ready,
        output o_riscv_pps_ready,
        output o_riscv_pps_valid,
        output o_riscv_pps_data
    );

    modport master (
        output i_riscv_pps_valid,
        output i_riscv_pps_data,
        output i_riscv_pps_ready,
        input  o_riscv_pps_ready,
        input  o_riscv_pps_valid,
        input  o_riscv_pps_data
    );
endinterface

// File: rtl/riscv_ppreg_skid.sv
// rtl/riscv_ppreg_skid.sv - elastic two-entry skid pipeline register with saturating stall counter
module riscv_ppreg_skid #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic             i_riscv_pps_clk,
    input  logic             i_riscv_pps_rst_n,
    input  logic             i_riscv_pps_flush,
    riscv_ppreg_skid_if.slave pps,
    output logic [1:0]       o_riscv_pps_occ,
    output logic [CNT_W-1:0] o_riscv_pps_stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              main_valid;
    logic              in_xfer;
    logic              out_xfer;

    assign main_valid = (state_q != EMPTY);
    assign in_xfer    = pps.i_riscv_pps_valid & ready_q;
    assign out_xfer   = main_valid & pps.i_riscv_pps_ready;

    always_ff @(posedge i_riscv_pps_clk or negedge i_riscv_pps_rst_n) begin
        if (!i_riscv_pps_rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;

        if (main_valid && !pps.i_riscv_pps_ready && !i_riscv_pps_flush
            && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Flush zeroes the payload so killed slots look like bubbles downstream.
        if (i_riscv_pps_flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
            ready_d = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_d  = pps.i_riscv_pps_data;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_d = pps.i_riscv_pps_data;
                    end else if (in_xfer) begin
                        skid_d  = pps.i_riscv_pps_data;
                        ready_d = 1'b0;
                        state_d = FULL;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) begin
                        main_d  = skid_q;
                        ready_d = 1'b1;
                        state_d = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    ready_d = 1'b1;
                end
            endcase
        end
    end

    assign pps.o_riscv_pps_ready = ready_q;
    assign pps.o_riscv_pps_valid = main_valid;
    assign pps.o_riscv_pps_data  = main_q;
    assign o_riscv_pps_occ       = state_q;
    assign o_riscv_pps_stall_cnt = cnt_q;
endmodule

// File: tb/tb_riscv_ppreg_skid.sv
// tb/tb_riscv_ppreg_skid.sv - queue-model self-checking bench for riscv_ppreg_skid at three widths
module tb_riscv_ppreg_skid;
    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         vld_s [3];
    logic         rdy_s [3];
    logic         fl_s  [3];
    logic [127:0] dat_s [3];
    wire  [127:0] od    [3];
    wire          ov    [3];
    wire          ordy  [3];
    wire  [1:0]   occ   [3];
    wire  [15:0]  scnt  [3];
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    task automatic chk(input int g, input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL g%0d %s: got %0h expected %0h", g, nm, act, exp);
        end
    endtask

    // Instance 0 carries the directed tests (narrow counter to reach saturation quickly).
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DW = (g == 0) ? 8 : ((g == 1) ? 1 : 128);
        localparam int CW = (g == 0) ? 4 : 16;

        riscv_ppreg_skid_if #(.DATA_W(DW)) bus ();
        logic [CW-1:0] cnt_w;
        logic [1:0]    occ_w;

        assign bus.i_riscv_pps_valid = vld_s[g];
        assign bus.i_riscv_pps_ready = rdy_s[g];
        assign bus.i_riscv_pps_data  = dat_s[g][DW-1:0];

        riscv_ppreg_skid #(.DATA_W(DW), .CNT_W(CW)) u_dut (
            .i_riscv_pps_clk       (clk),
            .i_riscv_pps_rst_n     (rst_n),
            .i_riscv_pps_flush     (fl_s[g]),
            .pps                   (bus),
            .o_riscv_pps_occ       (occ_w),
            .o_riscv_pps_stall_cnt (cnt_w)
        );

        assign od[g]   = 128'(bus.o_riscv_pps_data);
        assign ov[g]   = bus.o_riscv_pps_valid;
        assign ordy[g] = bus.o_riscv_pps_ready;
        assign occ[g]  = occ_w;
        assign scnt[g] = 16'(cnt_w);

        // Model: a FIFO of at most two payloads plus the last value shown when empty.
        logic [DW-1:0] mq [$];
        logic [DW-1:0] last = '0;
        logic [DW-1:0] popped;
        int            mcnt = 0;
        bit            in_x, out_x;

        initial forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                last = '0;
                mcnt = 0;
            end else if (fl_s[g]) begin
                mq.delete();
                last = '0;
            end else begin
                out_x = (mq.size() > 0) && rdy_s[g];
                in_x  = vld_s[g] && (mq.size() < 2);
                if ((mq.size() > 0) && !rdy_s[g] && (mcnt < (1 << CW) - 1)) mcnt++;
                if (out_x) begin
                    popped = mq.pop_front();
                    if (mq.size() == 0) last = popped;
                end
                if (in_x) mq.push_back(dat_s[g][DW-1:0]);
            end
        end

        logic         pv = 1'b0, pr = 1'b0, pf = 1'b0, p_ok = 1'b0;
        logic [127:0] pd = '0;

        initial forever begin
            @(negedge clk);
            chk(g, "valid", 128'(ov[g]), 128'(mq.size() > 0));
            chk(g, "data", od[g], (mq.size() > 0) ? 128'(mq[0]) : 128'(last));
            chk(g, "ready", 128'(ordy[g]), 128'(mq.size() < 2));
            chk(g, "occ", 128'(occ[g]), 128'(mq.size()));
            chk(g, "stall_cnt", 128'(scnt[g]), 128'(mcnt));
            if (p_ok && rst_n && pv && !pr && !pf) begin
                chk(g, "stable_data", od[g], pd);
                chk(g, "stable_valid", 128'(ov[g]), 128'(1));
            end
            pv   = ov[g];
            pd   = od[g];
            pr   = rdy_s[g];
            pf   = fl_s[g];
            p_ok = rst_n;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input bit r, input bit f, input logic [127:0] d);
        vld_s[0] = v;
        rdy_s[0] = r;
        fl_s[0]  = f;
        dat_s[0] = d;
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            vld_s[g] = 1'b0;
            rdy_s[g] = 1'b0;
            fl_s[g]  = 1'b0;
            dat_s[g] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        chk(0, "reset_ready", 128'(ordy[0]), 128'(1));
        chk(0, "reset_valid", 128'(ov[0]), 128'(0));
        rst_n = 1'b1;

        // Streaming 0x1..0x8 with downstream always ready
        drive(0, 1, 0, 0);
        step();
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 0, 128'(i));
            step();
            chk(0, "stream_data", od[0], 128'(i));
            chk(0, "stream_ready", 128'(ordy[0]), 128'(1));
            chk(0, "stream_occ", 128'(occ[0]), 128'(1));
        end
        drive(0, 1, 0, 0);
        step();
        chk(0, "stream_cnt", 128'(scnt[0]), 128'(0));

        // Backpressure into the skid entry
        drive(1, 0, 0, 128'hA);
        step();
        chk(0, "bp_occ1", 128'(occ[0]), 128'(1));
        drive(1, 0, 0, 128'hB);
        step();
        chk(0, "bp_occ2", 128'(occ[0]), 128'(2));
        chk(0, "bp_ready0", 128'(ordy[0]), 128'(0));
        drive(0, 0, 0, 0);
        repeat (3) step();
        chk(0, "bp_hold", od[0], 128'hA);
        chk(0, "bp_cnt4", 128'(scnt[0]), 128'(4));
        drive(0, 1, 0, 0);
        step();
        chk(0, "bp_outB", od[0], 128'hB);
        chk(0, "bp_ready1", 128'(ordy[0]), 128'(1));
        step();
        chk(0, "bp_empty", 128'(occ[0]), 128'(0));

        // Flush while FULL, with a concurrent push that must be dropped
        drive(1, 0, 0, 128'h1);
        step();
        drive(1, 0, 0, 128'h2);
        step();
        drive(1, 0, 1, 128'hC);
        step();
        chk(0, "fl_valid", 128'(ov[0]), 128'(0));
        chk(0, "fl_data", od[0], 128'(0));
        chk(0, "fl_occ", 128'(occ[0]), 128'(0));
        chk(0, "fl_ready", 128'(ordy[0]), 128'(1));
        chk(0, "fl_cnt", 128'(scnt[0]), 128'(5));
        drive(0, 1, 0, 0);
        step();
        chk(0, "fl_noC", od[0], 128'(0));

        // Stall counter saturation at 15
        drive(1, 0, 0, 128'h7);
        step();
        drive(0, 0, 0, 0);
        repeat (20) step();
        chk(0, "sat_cnt", 128'(scnt[0]), 128'(15));
        chk(0, "sat_data", od[0], 128'h7);

        // Asynchronous reset while FULL
        drive(1, 0, 0, 128'h9);
        step();
        chk(0, "ar_full", 128'(occ[0]), 128'(2));
        #2;
        rst_n = 1'b0;
        #1;
        chk(0, "ar_valid", 128'(ov[0]), 128'(0));
        chk(0, "ar_data", od[0], 128'(0));
        chk(0, "ar_occ", 128'(occ[0]), 128'(0));
        chk(0, "ar_ready", 128'(ordy[0]), 128'(1));
        chk(0, "ar_cnt", 128'(scnt[0]), 128'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(1, 1, 0, 128'h5A);
        step();
        chk(0, "ar_push", od[0], 128'h5A);
        chk(0, "ar_push_v", 128'(ov[0]), 128'(1));
        drive(0, 1, 0, 0);
        step();

        // Random traffic on all three widths
        for (int c = 0; c < 600; c++) begin
            for (int g = 0; g < 3; g++) begin
                vld_s[g] = 1'($urandom_range(0, 1));
                rdy_s[g] = ($urandom_range(0, 3) != 0);
                fl_s[g]  = ($urandom_range(0, 15) == 0);
                dat_s[g] = {$urandom, $urandom, $urandom, $urandom};
            end
            step();
        end
        for (int g = 0; g < 3; g++) begin
            vld_s[g] = 1'b0;
            rdy_s[g] = 1'b1;
            fl_s[g]  = 1'b0;
        end
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
